// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store to single-master bus bridge.
// Three-state FSM (IDLE/BUSY/DONE) drives registered bus outputs with
// big-endian byte lanes and returns an aligned, extended load result.
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort a bus cycle that
// has waited 256 BUSY cycles without an acknowledge.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_sign_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    output logic [31:0] rdata_o,
    output logic        stallreq_o,
    output logic        err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q;
    logic        cyc_q, stb_q, we_q;
    logic [31:0] adr_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        kill_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sign_q;
`ifdef MEM_BUS_TIMEOUT_EN
    logic [7:0]  tmo_q;
`endif

    logic        misaligned;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d;
    logic [31:0] load_d;
    logic        killed;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Decode the incoming request: alignment, byte lanes, replicated store data.
    always_comb begin
        misaligned = 1'b0;
        sel_d      = 4'b1111;
        wdata_d    = mem_wdata_i;
        case (mem_size_i)
            2'b00: begin
                sel_d   = 4'b1000 >> mem_addr_i[1:0];
                wdata_d = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = mem_addr_i[0];
                sel_d      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_d    = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                misaligned = (mem_addr_i[1:0] != 2'b00);
            end
        endcase
    end

    // Extract and extend the load result from the latched offset/size/sign.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus_dat_i[31:24];
            2'd1:    ld_byte = bus_dat_i[23:16];
            2'd2:    ld_byte = bus_dat_i[15:8];
            default: ld_byte = bus_dat_i[7:0];
        endcase
        ld_half = off_q[1] ? bus_dat_i[15:0] : bus_dat_i[31:16];
        case (size_q)
            2'b00:   load_d = {{24{sign_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_d = {{16{sign_q & ld_half[15]}}, ld_half};
            default: load_d = bus_dat_i;
        endcase
    end

    // A flush in the same cycle as the ack counts as a kill.
    assign killed = kill_q | flush_i;

    // FSM, bus outputs, load result and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            kill_q  <= 1'b0;
            off_q   <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_req_i && !flush_i) begin
                        if (misaligned) begin
                            state_q <= S_DONE;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q <= S_BUSY;
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= mem_we_i;
                            adr_q   <= {mem_addr_i[31:2], 2'b00};
                            sel_q   <= sel_d;
                            dat_q   <= wdata_d;
                            off_q   <= mem_addr_i[1:0];
                            size_q  <= mem_size_i;
                            sign_q  <= mem_sign_i;
                            kill_q  <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        kill_q <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        if (!we_q && !killed) begin
                            rdata_q <= load_d;
                        end
                        state_q <= killed ? S_IDLE : S_DONE;
                    end
`ifdef MEM_BUS_TIMEOUT_EN
                    else if (tmo_q == 8'hFF) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        if (!killed) begin
                            rdata_q <= '0;
                        end
                        state_q <= killed ? S_IDLE : S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_cyc_o = cyc_q;
    assign bus_stb_o = stb_q;
    assign bus_we_o  = we_q;
    assign bus_adr_o = adr_q;
    assign bus_sel_o = sel_q;
    assign bus_dat_o = dat_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;

    assign stallreq_o = !rst &&
                        (((state_q == S_IDLE) && mem_req_i && !flush_i) ||
                         ((state_q == S_BUSY) && !kill_q && !flush_i));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i, mem_we_i, mem_sign_i, flush_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic [1:0]  mem_size_i;
    logic        bus_cyc_o, bus_stb_o, bus_we_o;
    logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i, rdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i, stallreq_o, err_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned stall_cnt;
    int unsigned n;
    int unsigned errs;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_size_i(mem_size_i), .mem_sign_i(mem_sign_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
        .rdata_o(rdata_o), .stallreq_o(stallreq_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sign, input logic [31:0] wdata);
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_size_i  = size;
        mem_sign_i  = sign;
        mem_wdata_i = wdata;
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sign_i = 1'b0; flush_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; mem_size_i = '0; bus_dat_i = '0; bus_ack_i = 1'b0;
        tick(); tick();
        mem_req_i = 1'b1; #1;
        check("rst_cyc", {31'd0, bus_cyc_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_stall", {31'd0, stallreq_o}, 32'd0);
        mem_req_i = 1'b0; rst = 1'b0;
        tick();

        // lb 0x103, sign, ack after two waits
        stall_cnt = 0;
        bus_dat_i = 32'h123456F0;
        req(1'b0, 32'h103, 2'b00, 1'b1, 32'h0);
        stall_cnt += stallreq_o;
        tick(); mem_req_i = 1'b0; #1;
        check("lb_cyc", {31'd0, bus_cyc_o}, 32'd1);
        check("lb_stb", {31'd0, bus_stb_o}, 32'd1);
        check("lb_sel", {28'd0, bus_sel_o}, 32'h1);
        check("lb_adr", bus_adr_o, 32'h100);
        stall_cnt += stallreq_o;
        tick(); stall_cnt += stallreq_o;
        check("lb_hold_cyc", {31'd0, bus_cyc_o}, 32'd1);
        tick(); bus_ack_i = 1'b1; #1; stall_cnt += stallreq_o;
        tick(); bus_ack_i = 1'b0; #1; stall_cnt += stallreq_o;
        check("lb_done_cyc", {31'd0, bus_cyc_o}, 32'd0);
        check("lb_rdata", rdata_o, 32'hFFFFFFF0);
        check("lb_err", {31'd0, err_o}, 32'd0);
        check("lb_stall_cycles", stall_cnt, 32'd4);
        tick();

        // sh 0x202
        req(1'b1, 32'h202, 2'b01, 1'b0, 32'h0000BEEF);
        tick(); mem_req_i = 1'b0;
        check("sh_sel", {28'd0, bus_sel_o}, 32'h3);
        check("sh_dat", bus_dat_o, 32'hBEEFBEEF);
        check("sh_we", {31'd0, bus_we_o}, 32'd1);
        check("sh_adr", bus_adr_o, 32'h200);
        bus_dat_i = 32'hDEADBEEF; bus_ack_i = 1'b1;
        tick(); bus_ack_i = 1'b0; #1;
        check("sh_rdata", rdata_o, 32'hFFFFFFF0);
        check("sh_done_cyc", {31'd0, bus_cyc_o}, 32'd0);
        tick();

        // ack in IDLE is ignored
        bus_ack_i = 1'b1;
        tick(); bus_ack_i = 1'b0; #1;
        check("idle_ack_cyc", {31'd0, bus_cyc_o}, 32'd0);
        check("idle_ack_rdata", rdata_o, 32'hFFFFFFF0);

        // lw 0x101 misaligned: no bus cycle, one err pulse, DONE one cycle
        req(1'b0, 32'h101, 2'b10, 1'b0, 32'h0);
        check("mis_stall_idle", {31'd0, stallreq_o}, 32'd1);
        tick();
        check("mis_cyc", {31'd0, bus_cyc_o}, 32'd0);
        check("mis_err", {31'd0, err_o}, 32'd1);
        check("mis_rdata", rdata_o, 32'd0);
        check("mis_stall_done", {31'd0, stallreq_o}, 32'd0);
        tick();
        check("mis_err_clr", {31'd0, err_o}, 32'd0);
        check("mis_back_idle", {31'd0, stallreq_o}, 32'd1);
        mem_req_i = 1'b0; #1;

        // size 11 behaves as word: 0x002 is misaligned
        req(1'b0, 32'h002, 2'b11, 1'b0, 32'h0);
        tick(); mem_req_i = 1'b0; #1;
        check("sz3_err", {31'd0, err_o}, 32'd1);
        check("sz3_cyc", {31'd0, bus_cyc_o}, 32'd0);
        tick();

        // flush in IDLE suppresses the access
        req(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        flush_i = 1'b1; #1;
        check("fl_idle_stall", {31'd0, stallreq_o}, 32'd0);
        tick(); mem_req_i = 1'b0; flush_i = 1'b0; #1;
        check("fl_idle_cyc", {31'd0, bus_cyc_o}, 32'd0);

        // lw with same-cycle ack: IDLE, BUSY, DONE
        bus_dat_i = 32'hCAFEF00D;
        req(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        tick(); mem_req_i = 1'b0; bus_ack_i = 1'b1;
        tick(); bus_ack_i = 1'b0; #1;
        check("lw_rdata", rdata_o, 32'hCAFEF00D);
        tick();

        // lw killed by flush in second BUSY cycle, ack three cycles later
        req(1'b0, 32'h104, 2'b10, 1'b0, 32'h0);
        tick(); mem_req_i = 1'b0;
        tick(); flush_i = 1'b1; #1;
        check("kill_stall_flush", {31'd0, stallreq_o}, 32'd0);
        tick(); flush_i = 1'b0; #1;
        check("kill_stall_after", {31'd0, stallreq_o}, 32'd0);
        check("kill_cyc_held", {31'd0, bus_cyc_o}, 32'd1);
        tick();
        tick(); bus_dat_i = 32'h11111111; bus_ack_i = 1'b1;
        tick(); bus_ack_i = 1'b0; #1;
        check("kill_cyc_drop", {31'd0, bus_cyc_o}, 32'd0);
        check("kill_rdata", rdata_o, 32'hCAFEF00D);
        // IDLE (not DONE): a new request stalls immediately
        bus_dat_i = 32'h1234F00D;
        req(1'b0, 32'h10A, 2'b01, 1'b1, 32'h0);
        check("kill_no_done", {31'd0, stallreq_o}, 32'd1);
        tick(); mem_req_i = 1'b0;
        check("lh_sel", {28'd0, bus_sel_o}, 32'h3);
        bus_ack_i = 1'b1;
        tick(); bus_ack_i = 1'b0; #1;
        check("lh_rdata", rdata_o, 32'hFFFFF00D);
        tick();

        // no ack: timeout or indefinite wait
        req(1'b1, 32'h200, 2'b10, 1'b0, 32'hA5A5A5A5);
        tick(); mem_req_i = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
        n = 0; errs = 0;
        while (bus_cyc_o && n < 300) begin
            n++;
            tick();
            errs += err_o;
        end
        check("tmo_busy_cycles", n, 32'd256);
        check("tmo_err_once", errs, 32'd1);
        check("tmo_rdata", rdata_o, 32'd0);
        tick(); tick();
        req(1'b1, 32'h200, 2'b10, 1'b0, 32'hA5A5A5A5);
        tick(); mem_req_i = 1'b0;
`else
        repeat (1000) tick();
        check("noack_cyc", {31'd0, bus_cyc_o}, 32'd1);
        check("noack_stall", {31'd0, stallreq_o}, 32'd1);
`endif
        check("pre_rst_dat", bus_dat_o, 32'hA5A5A5A5);

        // reset mid-BUSY
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        check("mrst_cyc", {31'd0, bus_cyc_o}, 32'd0);
        check("mrst_stb", {31'd0, bus_stb_o}, 32'd0);
        check("mrst_we", {31'd0, bus_we_o}, 32'd0);
        check("mrst_adr", bus_adr_o, 32'd0);
        check("mrst_sel", {28'd0, bus_sel_o}, 32'd0);
        check("mrst_dat", bus_dat_o, 32'd0);
        check("mrst_rdata", rdata_o, 32'd0);
        check("mrst_err", {31'd0, err_o}, 32'd0);
        check("mrst_stall", {31'd0, stallreq_o}, 32'd0);

        // lhu at 0x0
        bus_dat_i = 32'h8001ABCD;
        req(1'b0, 32'h0, 2'b01, 1'b0, 32'h0);
        tick(); mem_req_i = 1'b0; bus_ack_i = 1'b1;
        check("lhu_sel", {28'd0, bus_sel_o}, 32'hC);
        tick(); bus_ack_i = 1'b0; #1;
        check("lhu_rdata", rdata_o, 32'h00008001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
